// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAM match sequencer.
package cam_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DIR_ASC  = 0;
    localparam int DIR_DESC = 1;

    function automatic int cam_lines(input int index_width);
        return 1 << index_width;
    endfunction

endpackage

// File: rtl/cam_rot_prienc.sv
// Window rotation plus lowest/highest set-bit encoder over the pending vector.
module cam_rot_prienc
    import cam_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int DIR         = DIR_ASC,
    localparam int N          = cam_lines(INDEX_WIDTH)
) (
    input  logic [N-1:0]           vec_i,
    input  logic [INDEX_WIDTH-1:0] rot_i,
    output logic [N-1:0]           rot_o,
    input  logic [N-1:0]           pend_i,
    output logic [INDEX_WIDTH-1:0] sel_o,
    output logic                   single_o
);

    logic [2*N-1:0]         dbl;
    logic [INDEX_WIDTH:0]   rot_ext;

    // Rotate right: bit 0 of the result is the window start.
    assign dbl     = {vec_i, vec_i};
    assign rot_ext = {1'b0, rot_i};
    assign rot_o   = dbl[rot_ext +: N];

    generate
        if (DIR == DIR_ASC) begin : g_asc
            always_comb begin
                sel_o = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (pend_i[i]) sel_o = INDEX_WIDTH'(i);
                end
            end
        end else begin : g_desc
            always_comb begin
                sel_o = '0;
                for (int i = 0; i < N; i++) begin
                    if (pend_i[i]) sel_o = INDEX_WIDTH'(i);
                end
            end
        end
    endgenerate

    assign single_o = (pend_i != '0) && ((pend_i & (pend_i - N'(1))) == '0);

endmodule

// File: rtl/cam_match_sequencer.sv
// Captures a CAM match vector inside a (possibly wrapping) index window and
// streams every matched index one per cycle over valid/ready.
module cam_match_sequencer
    import cam_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int DIR         = DIR_ASC,
    localparam int N          = cam_lines(INDEX_WIDTH)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [N-1:0]           match_i,
    input  logic [INDEX_WIDTH-1:0] start_i,
    input  logic [INDEX_WIDTH-1:0] end_i,
    input  logic                   abort_i,
    input  logic                   ready_i,
    output logic                   valid_o,
    output logic [INDEX_WIDTH-1:0] out_o,
    output logic                   last_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   none_o,
    output logic [INDEX_WIDTH:0]   count_o
);

    state_t                 state;
    logic [N-1:0]           pending;
    logic [INDEX_WIDTH-1:0] start_q;
    logic [N-1:0]           window;
    logic [N-1:0]           rot_vec;
    logic [INDEX_WIDTH-1:0] sel;
    logic                   single;

    always_comb begin
        window = '0;
        for (int i = 0; i < N; i++) begin
            if (start_i <= end_i)
                window[i] = (INDEX_WIDTH'(i) >= start_i) && (INDEX_WIDTH'(i) <= end_i);
            else
                window[i] = (INDEX_WIDTH'(i) >= start_i) || (INDEX_WIDTH'(i) <= end_i);
        end
    end

    cam_rot_prienc #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .DIR         (DIR)
    ) u_enc (
        .vec_i    (match_i & window),
        .rot_i    (start_i),
        .rot_o    (rot_vec),
        .pend_i   (pending),
        .sel_o    (sel),
        .single_o (single)
    );

    // Beat outputs come from registers only; ready_i never reaches them.
    assign valid_o = (state == SCAN);
    assign busy_o  = valid_o;
    assign out_o   = valid_o ? INDEX_WIDTH'(sel + start_q) : '0;
    assign last_o  = valid_o & single;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            pending <= '0;
            start_q <= '0;
            count_o <= '0;
            done_o  <= 1'b0;
            none_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            none_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_i) begin
                        pending <= rot_vec;
                        start_q <= start_i;
                        count_o <= '0;
                        if (rot_vec != '0) begin
                            state <= SCAN;
                        end else begin
                            done_o <= 1'b1;
                            none_o <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    // Abort beats a simultaneous handshake; that beat is not counted.
                    if (abort_i) begin
                        state   <= IDLE;
                        pending <= '0;
                    end else if (ready_i) begin
                        pending <= pending & ~(N'(1) << sel);
                        count_o <= count_o + (INDEX_WIDTH+1)'(1);
                        if (single) begin
                            state  <= IDLE;
                            done_o <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cam_match_sequencer.md
# cam_match_sequencer

Sequential, parametrised successor to the CAM output priority encoder. On a load it captures the CAM match vector, restricts it to a start/end index window that may wrap, and emits every matched index one per cycle over a valid/ready handshake. Emission order is fixed by a direction parameter. It sits between the CAM match lines and the FIX field-dispatch logic, so downstream logic sees every match, not only the highest-priority one.

## Interface
- INDEX_WIDTH, 5: index width; N = 1 << INDEX_WIDTH match lines
- DIR, 0: 0 = ascending from start_i (wrapping), 1 = descending from end_i (wrapping)

- clk_i  in  1  single clock; all logic on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- load_i  in  1  capture match_i/start_i/end_i; honoured only when busy_o = 0
- match_i  in  N  raw CAM match vector
- start_i  in  INDEX_WIDTH  window start, inclusive
- end_i  in  INDEX_WIDTH  window end, inclusive
- abort_i  in  1  drop the current scan
- ready_i  in  1  consumer accepts out_o
- valid_o  out  1  out_o holds a matched index
- out_o  out  INDEX_WIDTH  matched index
- last_o  out  1  current beat is the final match of the scan
- busy_o  out  1  scan in progress
- done_o  out  1  one-cycle pulse at the end of a scan
- none_o  out  1  qualifies done_o: the window held no matches
- count_o  out  INDEX_WIDTH+1  beats accepted in the current or most recent scan

## Operation
- States: IDLE, SCAN.
- Window:
  - start_i <= end_i: indices start_i..end_i.
  - start_i > end_i: indices start_i..N-1 followed by 0..end_i (wrap).
  - start_i == end_i: single index.
- IDLE & load_i:
  - pending <= (match_i & window) rotated right by start_i, so bit 0 maps to start_i. Latch start_i and end_i.
  - count_o <= 0.
  - pending nonzero: go to SCAN.
  - pending zero: stay IDLE; done_o = 1 and none_o = 1 next cycle.
- SCAN:
  - DIR 0: selected bit = lowest set bit of pending.
  - DIR 1: selected bit = highest set bit, counting down from the end_i position.
  - out_o = (k + start) mod N, where k is the selected bit position.
  - last_o = 1 when pending has exactly one bit set.
- Handshake valid_o & ready_i:
  - Clear the selected bit; count_o + 1.
  - If last_o: go to IDLE; done_o = 1, none_o = 0 next cycle.
- Input handling:
  - load_i while busy_o = 1: ignored.
  - load_i in the cycle done_o is high: accepted (state is already IDLE).
- abort_i in SCAN:
  - Next cycle IDLE; pending cleared; no done_o; count_o holds.
  - abort_i together with a handshake: abort wins and the beat is not counted.
- rst_i: state IDLE, pending 0, all outputs 0, count_o 0. Applies mid-scan too; no done_o.

## Timing
- load_i at cycle t: first valid_o at t+1. Empty window: done_o at t+1.
- Throughput: one index per cycle while ready_i = 1.
- Final handshake at t: done_o at t+1, busy_o low at t+1.
- While valid_o & !ready_i: out_o and last_o stay stable.
- valid_o, out_o and last_o are combinational from registers only, with no combinational path from ready_i.
- count_o is registered and holds after done_o until the next accepted load.

## Structure
- Package cam_pkg:
  - state enum typedef (IDLE, SCAN)
  - DIR_ASC / DIR_DESC constants
  - function computing N from INDEX_WIDTH
- Sub-module cam_rot_prienc: combinational rotate, lowest/highest-set-bit encoder, and single-bit detect, parametrised by INDEX_WIDTH and DIR.
- The top level holds the FSM, pending register, counter and handshake.

## Test plan
All scenarios use INDEX_WIDTH = 5 and a single load at cycle t.
- Ascending:
  - Stimulus: DIR 0, match 0x0000_0091, window 0..31, ready_i = 1.
  - Response: out_o 0, 4, 7 at t+1..t+3; last_o with 7; done_o at t+4; count_o = 3.
- Wrap:
  - Stimulus: match 0x6000_0022, window 28..3.
  - Response: out_o 29, 30, 1 in that order; bit 5 never emitted.
- Empty window:
  - Stimulus: match 0x0000_0100, window 0..7.
  - Response: no valid_o; done_o = 1 and none_o = 1 at t+1; count_o = 0.
- Backpressure:
  - Stimulus: vector from the ascending case; ready_i low for 3 cycles after the first valid_o.
  - Response: out_o = 0 held stable for those cycles, then 4 and 7 follow.
- Descending:
  - Stimulus: DIR 1, match 0x0000_0091, window 0..31.
  - Response: out_o 7, 4, 0.
- Abort, load and reset during a scan:
  - load_i during SCAN: ignored.
  - abort_i on the second beat: IDLE next cycle; count_o = 1; no done_o.
  - rst_i mid-scan: all outputs 0 the next cycle.
